// File: rtl/linebuf3_tap.sv
// Row-tap generator for a 3x3 window: keeps the two previous image rows in line
// memories and emits vertically aligned taps (top, middle, bottom) per input pixel.
module linebuf3_tap #(
    parameter int XWIDTH = 12,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int CW     = 10,
    parameter int RW     = 9
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iSOF,
    input  logic              iDVAL,
    input  logic [XWIDTH-1:0] iDATA,
    output logic [XWIDTH-1:0] oX0,
    output logic [XWIDTH-1:0] oX1,
    output logic [XWIDTH-1:0] oX2,
    output logic              oDVAL,
    output logic              oEdge,
    output logic [CW-1:0]     oCol,
    output logic [RW-1:0]     oRow,
    output logic              oEOF
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    // Line memories: r_lm0 holds the older row, r_lm1 the newer one. Not reset.
    logic [XWIDTH-1:0] r_lm0 [IMG_W];
    logic [XWIDTH-1:0] r_lm1 [IMG_W];

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    logic [CW-1:0]     w_col;
    logic [RW-1:0]     w_row;
    logic              w_col_last;
    logic              w_row_last;
    logic [CW-1:0]     w_col_nxt;
    logic [RW-1:0]     w_row_nxt;
    logic              w_edge;
    logic              w_eof;
    logic [XWIDTH-1:0] w_rd0;
    logic [XWIDTH-1:0] w_rd1;

    // A start-of-frame pulse re-labels the current pixel as (0,0) before anything uses it.
    assign w_col      = iSOF ? '0 : r_col;
    assign w_row      = iSOF ? '0 : r_row;
    assign w_col_last = (w_col == COL_LAST);
    assign w_row_last = (w_row == ROW_LAST);
    assign w_col_nxt  = w_col_last ? '0 : w_col + CW'(1);
    assign w_row_nxt  = w_col_last ? (w_row_last ? '0 : w_row + RW'(1)) : w_row;
    assign w_edge     = (w_row >= RW'(2)) && (w_col >= CW'(2));
    assign w_eof      = w_col_last && w_row_last;
    assign w_rd0      = r_lm0[w_col];
    assign w_rd1      = r_lm1[w_col];

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_col <= '0;
            r_row <= '0;
        end else if (iDVAL) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end else if (iSOF) begin
            r_col <= '0;
            r_row <= '0;
        end
    end

    // Read-before-write: the taps see the rows as they were before this pixel shifts in.
    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            r_lm0[w_col] <= w_rd1;
            r_lm1[w_col] <= iDATA;
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oX0   <= '0;
            oX1   <= '0;
            oX2   <= '0;
            oDVAL <= 1'b0;
            oEdge <= 1'b0;
            oCol  <= '0;
            oRow  <= '0;
            oEOF  <= 1'b0;
        end else if (iDVAL) begin
            oX0   <= w_rd0;
            oX1   <= w_rd1;
            oX2   <= iDATA;
            oDVAL <= 1'b1;
            oEdge <= w_edge;
            oCol  <= w_col;
            oRow  <= w_row;
            oEOF  <= w_eof;
        end else begin
            oDVAL <= 1'b0;
            oEdge <= 1'b0;
            oEOF  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_linebuf3_tap.sv
// Scoreboard bench for linebuf3_tap on a 4x4 image: directed frames, gaps, frame wrap,
// mid-frame start-of-frame and asynchronous reset.
module tb_linebuf3_tap;

    localparam int XW = 12;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int CW = 2;
    localparam int RW = 2;
    localparam int P  = RW + CW + 2;
    localparam int EW = P + 3 * XW + 2;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic          iSOF = 1'b0;
    logic          iDVAL = 1'b0;
    logic [XW-1:0] iDATA = '0;
    logic [XW-1:0] oX0, oX1, oX2;
    logic          oDVAL, oEdge, oEOF;
    logic [CW-1:0] oCol;
    logic [RW-1:0] oRow;

    always #5 iCLK = ~iCLK;

    linebuf3_tap #(.XWIDTH(XW), .IMG_W(IW), .IMG_H(IH), .CW(CW), .RW(RW)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSOF(iSOF), .iDVAL(iDVAL), .iDATA(iDATA),
        .oX0(oX0), .oX1(oX1), .oX2(oX2), .oDVAL(oDVAL), .oEdge(oEdge),
        .oCol(oCol), .oRow(oRow), .oEOF(oEOF)
    );

    // expected entry: {m0, m1, x0, x1, x2, edge, eof, col, row}; m0/m1 mark known top/middle taps
    logic [EW-1:0] exp_q[$];
    typedef logic [XW-1:0] pxq_t[$];
    pxq_t hist[IW];

    int n_checks = 0;
    int n_fail   = 0;
    int n_edge1  = 0;
    int n_edge0  = 0;
    int n_eof    = 0;
    logic [XW-1:0] s0[16], s1[16], s2[16];
    logic [3*XW+CW+RW-1:0] prev_taps = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pix(input logic [XW-1:0] d, input logic sof, input int r, input int c,
                            input bit expect_out);
        logic [EW-1:0] e;
        logic          m0, m1;
        logic [XW-1:0] x0, x1;
        int            n;
        @(negedge iCLK);
        iDVAL = 1'b1;
        iSOF  = sof;
        iDATA = d;
        n  = hist[c].size();
        m1 = (n >= 1);
        m0 = (n >= 2);
        x1 = m1 ? hist[c][n-1] : '0;
        x0 = m0 ? hist[c][n-2] : '0;
        e  = {m0, m1, x0, x1, d, 1'(r >= 2 && c >= 2), 1'(r == IH-1 && c == IW-1), CW'(c), RW'(r)};
        if (expect_out) exp_q.push_back(e);
        hist[c].push_back(d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge iCLK);
            iDVAL = 1'b0;
            iSOF  = 1'b0;
        end
    endtask

    task automatic frame(input int base, input bit sof_first, input bit gaps);
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                push_pix(XW'(base + r * 16 + c), sof_first && r == 0 && c == 0, r, c, 1'b1);
                if (gaps) idle(3);
            end
    endtask

    task automatic drain();
        int k = 0;
        idle(1);
        while (exp_q.size() != 0 && k < 50) begin
            @(negedge iCLK);
            k++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_snap(input string name, input int idx, input logic [XW-1:0] e0,
                              input logic [XW-1:0] e1, input logic [XW-1:0] e2);
        check({name, "_x0"}, 64'(s0[idx]), 64'(e0));
        check({name, "_x1"}, 64'(s1[idx]), 64'(e1));
        check({name, "_x2"}, 64'(s2[idx]), 64'(e2));
    endtask

    // Monitor: pops one expectation per oDVAL cycle; between pulses the taps must hold.
    initial begin
        logic [EW-1:0] e;
        int            idx;
        forever begin
            @(negedge iCLK);
            if (!iRST) begin
                prev_taps = '0;
            end else if (oDVAL) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_dval", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("row",  64'(oRow),  64'(e[RW-1:0]));
                    check("col",  64'(oCol),  64'(e[RW +: CW]));
                    check("eof",  64'(oEOF),  64'(e[RW+CW]));
                    check("edge", 64'(oEdge), 64'(e[RW+CW+1]));
                    check("x2",   64'(oX2),   64'(e[P +: XW]));
                    if (e[EW-2]) check("x1", 64'(oX1), 64'(e[P+XW +: XW]));
                    if (e[EW-1]) check("x0", 64'(oX0), 64'(e[P+2*XW +: XW]));
                end
                idx = int'({oRow, oCol});
                s0[idx] = oX0;
                s1[idx] = oX1;
                s2[idx] = oX2;
                if (oEdge) n_edge1++; else n_edge0++;
                if (oEOF) n_eof++;
            end else begin
                check("hold_taps", 64'({oX0, oX1, oX2, oCol, oRow}), 64'(prev_taps));
                check("idle_flags", 64'({oEdge, oEOF}), 64'd0);
            end
            if (iRST) prev_taps = {oX0, oX1, oX2, oCol, oRow};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("reset_outputs", 64'({oDVAL, oEdge, oEOF, oX0, oX1, oX2, oCol, oRow}), 64'd0);
        @(negedge iCLK);
        iRST = 1'b1;

        // continuous ramp frame
        n_edge1 = 0; n_edge0 = 0; n_eof = 0;
        frame(0, 1'b1, 1'b0);
        drain();
        check("edge_interior_count", 64'(n_edge1), 64'd4);
        check("edge_border_count",   64'(n_edge0), 64'd12);
        check("eof_count_ramp",      64'(n_eof),   64'd1);
        check_snap("ramp_2_2", 10, 12'h002, 12'h012, 12'h022);
        check_snap("ramp_3_3", 15, 12'h013, 12'h023, 12'h033);

        // same frame with three idle cycles after every pixel
        n_eof = 0;
        frame(0, 1'b1, 1'b1);
        drain();
        check("eof_count_gapped", 64'(n_eof), 64'd1);
        check_snap("gap_2_2", 10, 12'h002, 12'h012, 12'h022);
        check_snap("gap_3_3", 15, 12'h013, 12'h023, 12'h033);

        // back-to-back frames, second one without start-of-frame
        frame(0, 1'b1, 1'b0);
        frame(8'h80, 1'b0, 1'b0);
        drain();
        check_snap("wrap_0_0", 0, 12'h020, 12'h030, 12'h080);
        check_snap("wrap_2_2", 10, 12'h082, 12'h092, 12'h0A2);

        // start-of-frame while at (1,2): pixel becomes (0,0), next is (0,1) (col 1, row 0)
        n_eof = 0;
        for (int c = 0; c < IW; c++) push_pix(XW'(c), c == 0, 0, c, 1'b1);
        push_pix(12'h010, 1'b0, 1, 0, 1'b1);
        push_pix(12'h011, 1'b0, 1, 1, 1'b1);
        push_pix(12'h099, 1'b1, 0, 0, 1'b1);
        push_pix(12'h09A, 1'b0, 0, 1, 1'b1);
        push_pix(12'h09B, 1'b0, 0, 2, 1'b1);
        drain();
        check("eof_after_sof", 64'(n_eof), 64'd0);
        check_snap("sof_pix", 0, 12'h000, 12'h010, 12'h099);
        check("sof_next_x2", 64'(s2[1]), 64'h09A);

        // asynchronous reset while the taps show pixel (2,1)
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < IW; c++) push_pix(XW'(12'h200 + r * 16 + c), r == 0 && c == 0, r, c, 1'b1);
        push_pix(12'h220, 1'b0, 2, 0, 1'b1);
        push_pix(12'h221, 1'b0, 2, 1, 1'b0);
        @(posedge iCLK);
        #2;
        iRST  = 1'b0;
        iDVAL = 1'b0;
        #1;
        check("async_rst_outputs", 64'({oDVAL, oEdge, oEOF, oX0, oX1, oX2, oCol, oRow}), 64'd0);
        repeat (2) @(negedge iCLK);
        iRST = 1'b1;
        push_pix(12'h355, 1'b0, 0, 0, 1'b1);
        push_pix(12'h356, 1'b0, 0, 1, 1'b1);
        drain();
        check_snap("post_rst_0_0", 0, 12'h210, 12'h220, 12'h355);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
